coherency_config_arbiter: RTL and testbench



---
 rtl/coherency_ctrl_pkg.sv | 20 ++
 rtl/coherency_rr_arbiter.sv | 50 +++++
 rtl/coherency_config_arbiter.sv | 179 +++++++++++++++++
 tb/tb_coherency_config_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coherency_ctrl_pkg.sv
// rtl/coherency_ctrl_pkg.sv - shared address/size types, FSM states and chunk-size helper
package coherency_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SIZE_W-1:0] size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  function automatic size_t chunk_min(input size_t remaining, input size_t max_chunk);
    return (remaining > max_chunk) ? max_chunk : remaining;
  endfunction

endpackage

// File: rtl/coherency_rr_arbiter.sv
// rtl/coherency_rr_arbiter.sv - round-robin grant starting at rr_ptr, plus the rr_ptr register
module coherency_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               ptr_adv,
  input  logic [IW-1:0]      ptr_adv_idx,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
      if (en && !gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ptr_adv) begin
      rr_ptr_d = (ptr_adv_idx == IW'(NUM_REQ-1)) ? '0 : ptr_adv_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/coherency_config_arbiter.sv
// rtl/coherency_config_arbiter.sv - round-robin coherency-config master, splits requests into chunks
// Optional ack-timeout flag enabled by COH_CFG_ARB_TIMEOUT_EN.
module coherency_config_arbiter
  import coherency_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_CHUNK      = 16,
  parameter int LINE_BYTES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  addr_t [NUM_REQ-1:0] req_base_addr,
  input  size_t [NUM_REQ-1:0] req_size,
  output logic [NUM_REQ-1:0]  req_ack,
  output logic                cfg_valid,
  output addr_t               cfg_base_addr,
  output size_t               cfg_size,
  input  logic                cfg_ack,
  output logic                cfg_timeout_err
);

  localparam int    IW          = $clog2(NUM_REQ);
  localparam int    LB_SH       = $clog2(LINE_BYTES);
  localparam size_t MAX_CHUNK_S = size_t'(MAX_CHUNK);

  if (MAX_CHUNK < 1 || MAX_CHUNK >= (1 << SIZE_W) || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("coherency_config_arbiter: size_t cannot hold MAX_CHUNK or bad TIMEOUT_CYCLES");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  addr_t              cur_base_q, cur_base_d;
  size_t              remaining_q, remaining_d;
  logic               cfg_valid_q, cfg_valid_d;
  addr_t              cfg_base_q, cfg_base_d;
  size_t              cfg_size_q, cfg_size_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;

  logic               gnt_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               ptr_adv;

  coherency_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .en         (state_q == IDLE),
    .ptr_adv    (ptr_adv),
    .ptr_adv_idx(gidx_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    cur_base_d  = cur_base_q;
    remaining_d = remaining_q;
    cfg_valid_d = cfg_valid_q;
    cfg_base_d  = cfg_base_q;
    cfg_size_d  = cfg_size_q;
    req_ack_d   = '0;
    ptr_adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d       = gnt;
          gidx_d      = gnt_idx;
          cur_base_d  = req_base_addr[gnt_idx];
          remaining_d = req_size[gnt_idx];
          if (req_size[gnt_idx] == '0) begin
            state_d = RESP;
          end else begin
            state_d     = ISSUE;
            cfg_valid_d = 1'b1;
            cfg_base_d  = req_base_addr[gnt_idx];
            cfg_size_d  = chunk_min(req_size[gnt_idx], MAX_CHUNK_S);
          end
        end
      end
      ISSUE: begin
        if (cfg_valid_q) begin
          if (cfg_ack) begin
            remaining_d = remaining_q - cfg_size_q;
            cur_base_d  = cur_base_q + (addr_t'(cfg_size_q) << LB_SH);
            cfg_valid_d = 1'b0;
            if (remaining_d == '0) begin
              state_d   = RESP;
              req_ack_d = gnt_q;
            end
          end
        end else begin
          cfg_valid_d = 1'b1;
          cfg_base_d  = cur_base_q;
          cfg_size_d  = chunk_min(remaining_q, MAX_CHUNK_S);
        end
      end
      RESP: begin
        // Zero-length requests arrive without a registered ack, so they spend one extra cycle here.
        if (req_ack_q != '0) begin
          ptr_adv = 1'b1;
          state_d = IDLE;
        end else begin
          req_ack_d = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      cur_base_q  <= '0;
      remaining_q <= '0;
      cfg_valid_q <= 1'b0;
      cfg_base_q  <= '0;
      cfg_size_q  <= '0;
      req_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      cur_base_q  <= cur_base_d;
      remaining_q <= remaining_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_base_q  <= cfg_base_d;
      cfg_size_q  <= cfg_size_d;
      req_ack_q   <= req_ack_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign cfg_valid     = cfg_valid_q;
  assign cfg_base_addr = cfg_base_q;
  assign cfg_size      = cfg_size_q;

`ifdef COH_CFG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_err_q, to_err_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
    if (cfg_valid_q && cfg_ack) begin
      to_cnt_d = '0;
    end else if (cfg_valid_q && (to_cnt_q != TW'(TIMEOUT_CYCLES))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    if (to_cnt_d == TW'(TIMEOUT_CYCLES)) begin
      to_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign cfg_timeout_err = to_err_q;
`else
  assign cfg_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_coherency_config_arbiter.sv
// tb/tb_coherency_config_arbiter.sv - scoreboard bench for coherency_config_arbiter
module tb_coherency_config_arbiter;
  import coherency_ctrl_pkg::*;

  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  addr_t [NR-1:0] req_base_addr;
  size_t [NR-1:0] req_size;
  logic [NR-1:0]  req_ack;
  logic           cfg_valid;
  addr_t          cfg_base_addr;
  size_t          cfg_size;
  logic           cfg_ack;
  logic           cfg_timeout_err;

  typedef struct packed {
    addr_t base;
    size_t size;
  } chunk_t;

  typedef struct {
    int idx;
    int seen;
    bit zero;
  } ack_t;

  chunk_t exp_cfg[$];
  ack_t   exp_ack[$];
  chunk_t hold;
  chunk_t got;
  ack_t   ent;
  bit     holding = 1'b0;
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     stall_target = 0;
  int     stall_cnt = 0;
  int     last_xfer_cyc = 0;

  coherency_config_arbiter #(
    .NUM_REQ(NR), .MAX_CHUNK(16), .LINE_BYTES(64), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_base_addr  (req_base_addr),
    .req_size       (req_size),
    .req_ack        (req_ack),
    .cfg_valid      (cfg_valid),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_size       (cfg_size),
    .cfg_ack        (cfg_ack),
    .cfg_timeout_err(cfg_timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + downstream responder: acks after stall_target stalled cycles and scores every event.
  always @(negedge clk) begin
    if (rst) begin
      cfg_ack   = 1'b0;
      stall_cnt = 0;
      holding   = 1'b0;
    end else begin
      if (req_ack != '0) begin
        if (exp_ack.size() == 0) begin
          check("req_ack_unexpected", 64'(req_ack), 64'd0);
        end else begin
          ent = exp_ack.pop_front();
          check("req_ack_onehot", 64'(req_ack), 64'd1 << ent.idx);
          if (ent.zero) check("req_ack_zero_latency", 64'(cyc - ent.seen), 64'd2);
          else          check("req_ack_latency", 64'(cyc - last_xfer_cyc), 64'd1);
        end
        req_valid = req_valid & ~req_ack;
      end
      if (cfg_valid) begin
        if (holding) begin
          check("stable_base", 64'(cfg_base_addr), 64'(hold.base));
          check("stable_size", 64'(cfg_size), 64'(hold.size));
        end else begin
          hold    = {cfg_base_addr, cfg_size};
          holding = 1'b1;
        end
        if (stall_cnt < stall_target) begin
          cfg_ack = 1'b0;
          stall_cnt++;
        end else begin
          cfg_ack       = 1'b1;
          stall_cnt     = 0;
          holding       = 1'b0;
          last_xfer_cyc = cyc;
          if (exp_cfg.size() == 0) begin
            check("cfg_unexpected", 64'(cfg_valid), 64'd0);
          end else begin
            got = exp_cfg.pop_front();
            check("cfg_base", 64'(cfg_base_addr), 64'(got.base));
            check("cfg_size", 64'(cfg_size), 64'(got.size));
          end
        end
      end else begin
        cfg_ack = 1'b0;
      end
    end
  end

  task automatic push_chunk(input addr_t b, input size_t s);
    exp_cfg.push_back({b, s});
  endtask

  task automatic push_ack(input int i, input bit z);
    ack_t a;
    a.idx  = i;
    a.seen = cyc;
    a.zero = z;
    exp_ack.push_back(a);
  endtask

  task automatic req(input int i, input addr_t b, input size_t s);
    req_base_addr[i] = b;
    req_size[i]      = s;
    req_valid[i]     = 1'b1;
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      #1;
      if (req_valid == '0 && exp_cfg.size() == 0 && exp_ack.size() == 0) done = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = '0;
    req_base_addr = '0;
    req_size      = '0;
    cfg_ack       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    check("rst_cfg_base", 64'(cfg_base_addr), 64'd0);
    check("rst_cfg_size", 64'(cfg_size), 64'd0);
    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_timeout_err", 64'(cfg_timeout_err), 64'd0);
    rst = 1'b0;

    // Single short request with immediate ack.
    @(negedge clk);
    push_chunk(32'h1000, 16'd5);
    push_ack(0, 1'b0);
    req(0, 32'h1000, 16'd5);
    @(negedge clk);
    check("first_valid_latency", 64'(cfg_valid), 64'd1);
    wait_done("single");

    // 40 lines split into 16/16/8.
    push_chunk(32'h2000, 16'd16);
    push_chunk(32'h2400, 16'd16);
    push_chunk(32'h2800, 16'd8);
    push_ack(1, 1'b0);
    req(1, 32'h2000, 16'd40);
    wait_done("split");

    // Reset so rr_ptr starts at 0, then all four requesters at once.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_chunk(32'h4000, 16'd1); push_ack(0, 1'b0);
    push_chunk(32'h5000, 16'd1); push_ack(1, 1'b0);
    push_chunk(32'h6000, 16'd1); push_ack(2, 1'b0);
    push_chunk(32'h7000, 16'd1); push_ack(3, 1'b0);
    req(0, 32'h4000, 16'd1);
    req(1, 32'h5000, 16'd1);
    req(2, 32'h6000, 16'd1);
    req(3, 32'h7000, 16'd1);
    wait_done("rr_all");
    push_chunk(32'h8000, 16'd1); push_ack(0, 1'b0);
    push_chunk(32'h9000, 16'd1); push_ack(2, 1'b0);
    req(2, 32'h9000, 16'd1);
    req(0, 32'h8000, 16'd1);
    wait_done("rr_pair");

    // Backpressure: 7 stalled cycles, just under the timeout threshold.
    stall_target = 7;
    push_chunk(32'hA000, 16'd3);
    push_ack(2, 1'b0);
    req(2, 32'hA000, 16'd3);
    wait_done("backpressure");
    check("timeout_err_below", 64'(cfg_timeout_err), 64'd0);

    // Eight stalled cycles reaches the threshold.
    stall_target = 8;
    push_chunk(32'hB000, 16'd2);
    push_ack(3, 1'b0);
    req(3, 32'hB000, 16'd2);
    wait_done("timeout");
    stall_target = 0;
`ifdef COH_CFG_ARB_TIMEOUT_EN
    check("timeout_err_sticky", 64'(cfg_timeout_err), 64'd1);
`else
    check("timeout_err_off", 64'(cfg_timeout_err), 64'd0);
`endif

    // Zero-length request: no downstream transfer, ack two cycles after being seen.
    push_ack(0, 1'b1);
    req(0, 32'hC000, 16'd0);
    wait_done("zero");

    // Reset while chunk 2 of a 40-line request is waiting for its ack.
    push_chunk(32'hD000, 16'd16);
    push_ack(1, 1'b0);
    req(1, 32'hD000, 16'd40);
    for (int n = 0; n < 50 && exp_cfg.size() != 0; n++) @(negedge clk);
    stall_target = 100;
    for (int n = 0; n < 50 && !cfg_valid; n++) @(negedge clk);
    check("mid_chunk2_base", 64'(cfg_base_addr), 64'h0000_D400);
    check("mid_chunk2_size", 64'(cfg_size), 64'd16);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cfg_valid", 64'(cfg_valid), 64'd0);
    check("mid_rst_req_ack", 64'(req_ack), 64'd0);
    check("mid_rst_timeout_err", 64'(cfg_timeout_err), 64'd0);
    rst          = 1'b0;
    req_valid[1] = 1'b0;
    exp_ack.delete();
    stall_target = 0;
    repeat (4) @(negedge clk);
    check("mid_rst_no_cfg", 64'(cfg_valid), 64'd0);

    // Fresh request after the abandoned one proves the FSM is back in IDLE.
    push_chunk(32'hE000, 16'd4);
    push_ack(1, 1'b0);
    req(1, 32'hE000, 16'd4);
    wait_done("after_rst");

    check("exp_cfg_drained", 64'(exp_cfg.size()), 64'd0);
    check("exp_ack_drained", 64'(exp_ack.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
